// File: rtl/prescaled_counter_unit_if.sv
// Command/status bundle of the prescaled counter: 3-bit command and direction in,
// counter value and status flags out.
interface prescaled_counter_unit_if #(
    parameter int CNT_W = 13
);
    logic [2:0]       cmd;
    logic             down;
    logic [CNT_W-1:0] count;
    logic             tick;
    logic             ovf;
    logic             running;

    modport master (
        output cmd,
        output down,
        input  count,
        input  tick,
        input  ovf,
        input  running
    );

    modport slave (
        input  cmd,
        input  down,
        output count,
        output tick,
        output ovf,
        output running
    );
endinterface

// File: rtl/prescaled_counter_unit.sv
// Prescaled up/down event counter under IDLE/RUN/PAUSE command control; count moves
// DIV edges after entering RUN, flags are combinational, no backpressure (commands act every edge).
module prescaled_counter_unit #(
    parameter int DIV      = 5000,
    parameter int CNT_W    = 13,
    parameter bit SATURATE = 1'b0
) (
    input logic                   clk,
    input logic                   rst,
    prescaled_counter_unit_if.slave bus
);
    localparam int               PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             clear;
    logic             pause;
    logic             start;
    logic             in_run;
    logic             tick;
    logic             at_limit;

    assign clear    = bus.cmd[2];
    assign pause    = bus.cmd[1];
    assign start    = bus.cmd[0];
    assign in_run   = (state == ST_RUN);
    assign tick     = in_run && (pre == PRE_LAST);
    assign at_limit = bus.down ? (count == '0) : (count == CNT_MAX);

    // Pause outranks start, so pause+start never leaves IDLE or PAUSE.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (!pause && start) state_nxt = ST_RUN;
                ST_RUN:   if (pause) state_nxt = ST_PAUSE;
                ST_PAUSE: if (!pause && start) state_nxt = ST_RUN;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // A pause landing on a tick still wraps the prescaler to zero.
    always_comb begin
        pre_nxt = pre;
        if (clear) begin
            pre_nxt = '0;
        end else if (in_run) begin
            if (tick) begin
                pre_nxt = '0;
            end else if (!pause) begin
                pre_nxt = pre + PRE_W'(1);
            end
        end
    end

    always_comb begin
        count_nxt = count;
        if (clear) begin
            count_nxt = '0;
        end else if (tick) begin
            if (SATURATE && at_limit) begin
                count_nxt = count;
            end else if (bus.down) begin
                count_nxt = count - CNT_W'(1);
            end else begin
                count_nxt = count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            pre   <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            pre   <= pre_nxt;
            count <= count_nxt;
        end
    end

    assign bus.count   = count;
    assign bus.tick    = tick;
    assign bus.ovf     = tick && at_limit;
    assign bus.running = in_run;
endmodule

// File: tb/tb_prescaled_counter_unit.sv
// Directed bench: vector table plus hand sequences over four parameterisations.
module tb_prescaled_counter_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    prescaled_counter_unit_if #(.CNT_W(3))  ia ();
    prescaled_counter_unit_if #(.CNT_W(3))  is ();
    prescaled_counter_unit_if #(.CNT_W(3))  i1 ();
    prescaled_counter_unit_if #(.CNT_W(13)) id ();

    prescaled_counter_unit #(.DIV(4), .CNT_W(3), .SATURATE(1'b0)) u_a (.clk(clk), .rst(rst), .bus(ia));
    prescaled_counter_unit #(.DIV(4), .CNT_W(3), .SATURATE(1'b1)) u_s (.clk(clk), .rst(rst), .bus(is));
    prescaled_counter_unit #(.DIV(1), .CNT_W(3), .SATURATE(1'b0)) u_1 (.clk(clk), .rst(rst), .bus(i1));
    prescaled_counter_unit u_d (.clk(clk), .rst(rst), .bus(id));

    typedef struct packed {
        logic [2:0] cmd;
        logic       down;
        logic [2:0] count;
        logic       tick;
        logic       ovf;
        logic       running;
    } vec_t;

    vec_t vecs [33];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        // cmd, down, count, tick, ovf, running (observed before the edge of that row)
        vecs[0]  = '{3'b001, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'b000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{3'b000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{3'b000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{3'b000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{3'b000, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{3'b000, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{3'b010, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{3'b000, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'b011, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'b001, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'b000, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{3'b000, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{3'b000, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{3'b000, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{3'b000, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{3'b010, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{3'b000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{3'b001, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{3'b000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1};
        vecs[20] = '{3'b001, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1};
        vecs[21] = '{3'b000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1};
        vecs[22] = '{3'b100, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1};
        vecs[23] = '{3'b010, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[24] = '{3'b000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[25] = '{3'b001, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[26] = '{3'b000, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[27] = '{3'b000, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[28] = '{3'b000, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[29] = '{3'b000, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1};
        vecs[30] = '{3'b000, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1};
        vecs[31] = '{3'b111, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1};
        vecs[32] = '{3'b000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};

        rst = 1'b0;
        ia.cmd = 3'b000; ia.down = 1'b0;
        is.cmd = 3'b000; is.down = 1'b0;
        i1.cmd = 3'b000; i1.down = 1'b0;
        id.cmd = 3'b000; id.down = 1'b0;
        #2;
        chk("rst_count", int'(ia.count), 0);
        chk("rst_tick", int'(ia.tick), 0);
        chk("rst_ovf", int'(ia.ovf), 0);
        chk("rst_running", int'(ia.running), 0);
        chk("rst_d_count", int'(id.count), 0);
        chk("rst_1_tick", int'(i1.tick), 0);
        step();
        rst = 1'b1;

        for (int i = 0; i < 33; i++) begin
            ia.cmd  = vecs[i].cmd;
            ia.down = vecs[i].down;
            #1;
            chk($sformatf("vec%0d_count", i), int'(ia.count), int'(vecs[i].count));
            chk($sformatf("vec%0d_tick", i), int'(ia.tick), int'(vecs[i].tick));
            chk($sformatf("vec%0d_ovf", i), int'(ia.ovf), int'(vecs[i].ovf));
            chk($sformatf("vec%0d_running", i), int'(ia.running), int'(vecs[i].running));
            step();
        end
        ia.cmd = 3'b000; ia.down = 1'b0;

        // Wrap sequence: 13 ticks take the 3-bit counter 0..7,0..5.
        ia.cmd = 3'b001;
        step();
        ia.cmd = 3'b000;
        #1;
        for (int t = 0; t < 13; t++) begin
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("wrap%0d_notick", t), int'(ia.tick), 0);
                step();
            end
            chk($sformatf("wrap%0d_tick", t), int'(ia.tick), 1);
            chk($sformatf("wrap%0d_count", t), int'(ia.count), t % 8);
            chk($sformatf("wrap%0d_ovf", t), int'(ia.ovf), ((t % 8) == 7) ? 1 : 0);
            step();
        end
        chk("pre_arst_count", int'(ia.count), 5);

        // Asynchronous reset in mid-cycle.
        #2;
        rst = 1'b0;
        #1;
        chk("arst_count", int'(ia.count), 0);
        chk("arst_running", int'(ia.running), 0);
        chk("arst_tick", int'(ia.tick), 0);
        step();
        rst = 1'b1;
        step();
        chk("post_arst_running", int'(ia.running), 0);

        // Saturating mode: up to 7 and hold, then down to 0 and hold.
        is.cmd = 3'b001;
        step();
        is.cmd = 3'b000;
        #1;
        for (int t = 0; t < 10; t++) begin
            repeat (3) step();
            chk($sformatf("sat_up%0d_tick", t), int'(is.tick), 1);
            chk($sformatf("sat_up%0d_count", t), int'(is.count), (t > 7) ? 7 : t);
            chk($sformatf("sat_up%0d_ovf", t), int'(is.ovf), (t >= 7) ? 1 : 0);
            step();
        end
        is.down = 1'b1;
        #1;
        for (int t = 0; t < 10; t++) begin
            repeat (3) step();
            chk($sformatf("sat_dn%0d_count", t), int'(is.count), (t > 7) ? 0 : 7 - t);
            chk($sformatf("sat_dn%0d_ovf", t), int'(is.ovf), (t >= 7) ? 1 : 0);
            step();
        end

        // DIV=1: a tick on every RUN cycle.
        chk("div1_idle_tick", int'(i1.tick), 0);
        i1.cmd = 3'b001;
        step();
        i1.cmd = 3'b000;
        #1;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("div1_%0d_tick", k), int'(i1.tick), 1);
            chk($sformatf("div1_%0d_count", k), int'(i1.count), k % 8);
            chk($sformatf("div1_%0d_ovf", k), int'(i1.ovf), ((k % 8) == 7) ? 1 : 0);
            step();
        end

        // Default parameters: first increment 5000 edges after entering RUN.
        id.cmd = 3'b001;
        step();
        id.cmd = 3'b000;
        #1;
        repeat (4998) step();
        chk("dflt_4998_tick", int'(id.tick), 0);
        chk("dflt_4998_count", int'(id.count), 0);
        step();
        chk("dflt_4999_tick", int'(id.tick), 1);
        chk("dflt_4999_count", int'(id.count), 0);
        step();
        chk("dflt_5000_count", int'(id.count), 1);
        chk("dflt_5000_tick", int'(id.tick), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
